processing_unit_param: RTL and testbench
========================================

Name: processing_unit_param

Overview:
- Parametrised next-generation processing-unit datapath.
- Register file depth is parametrised and indexed (not one strobe per register); word and opcode widths are parametrised.
- ALU adds logic/shift/carry ops and a 4-bit NZCV flag register.
- Memory reads use a valid handshake that stalls all datapath updates until data arrives.
- Sits between the control unit (strobes and selects) and the memory (address out, word in).

Parameters:
WORD_SIZE, 8, datapath/bus width
NUM_REGS, 4, general registers (power of 2, ≥2)
OP_SIZE, 4, opcode field width (top OP_SIZE bits of the instruction)
RSEL, $clog2(NUM_REGS), register index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_word  in  WORD_SIZE  memory read data
mem_rd_valid  in  1  mem_word is valid this cycle
reg_wr_en  in  1  write Bus_2 into register reg_wr_sel
reg_wr_sel  in  RSEL  destination register index
bus1_sel  in  RSEL+1  Bus_1 source: 0..NUM_REGS-1 = register, NUM_REGS = PC, others = 0
bus2_sel  in  2  Bus_2 source: 0 ALU, 1 Bus_1, 2 mem_word, 3 constant 0
load_pc, inc_pc, load_ir, load_addr, load_y, load_flags  in  1 each  update strobes
instruction  out  WORD_SIZE  IR contents
address  out  WORD_SIZE  address register
Bus_1  out  WORD_SIZE  Bus_1 value
flags  out  4  registered {N,Z,C,V}
mem_rd_req  out  1  memory read in progress
stall  out  1  datapath update suppressed this cycle

Behaviour:
- Reset (rst=1 at posedge clk): all registers, PC, IR, address, Y, flags and the FSM are cleared. All registered outputs read 0 the cycle after. Reset overrides every strobe and any pending read.
- "Any strobe" = reg_wr_en | load_pc | inc_pc | load_ir | load_addr | load_y | load_flags.
- Read FSM, states IDLE and WAIT:
  - IDLE→WAIT when bus2_sel=2, any strobe is high, and mem_rd_valid=0.
  - WAIT→IDLE when mem_rd_valid=1. The held strobes commit on that same edge using mem_word.
  - In WAIT the control unit must hold strobes and selects stable; changing them is undefined.
  - If mem_rd_valid=1 in the first cycle, there is no WAIT and the load commits with zero added latency.
- mem_rd_req = (bus2_sel==2) & any strobe. Combinational, high from request until commit.
- stall = mem_rd_req & ~mem_rd_valid. While stall=1, no register, PC, IR, address, Y or flag changes.
- PC: load_pc has priority over inc_pc. Increment wraps modulo 2^WORD_SIZE (0xFF→0x00 at 8 bits).
- Several strobes in one cycle all load the same Bus_2 value.
- ALU inputs: a = Y, b = Bus_1. Opcode = instruction[WORD_SIZE-1 -: OP_SIZE]. Result is WORD_SIZE bits; carry is bit WORD_SIZE of the extended result.
  - NOP: 0
  - ADD: a+b, C = carry out
  - SUB: b−a, C = borrow
  - AND: a&b
  - NOT: ~b
  - OR: a|b
  - XOR: a^b
  - SHL: b<<1, C = b[MSB]
  - SHR: b>>1 logical, C = b[0]
  - ADC: a+b+C_reg
  - any other opcode: 0, C = 0
- Flags, computed combinationally from the ALU:
  - N = result MSB
  - Z = ~|result
  - V = signed overflow for ADD/ADC/SUB, 0 otherwise
  - Registered only on load_flags.
- Bus_1 and Bus_2 are fully combinational and never X.

Decomposition:
- Package proc_pkg holds:
  - opcode constants: NOP 0, ADD 1, SUB 2, AND 3, NOT 4, RD 5, WR 6, BR 7, BRZ 8, OR 9, XOR 10, SHL 11, SHR 12, ADC 13
  - bus2_sel encodings
  - flag bit positions
- Sub-module alu_flags: combinational ALU plus NZCV generation, instantiated once.

Test Plan:
- Reset → all outputs 0. Then reg_wr_sel=2 with mem_word=0x5A, bus2_sel=2, mem_rd_valid=1 → R2=0x5A next cycle, stall never high.
- Read with mem_rd_valid low 3 cycles, then high with mem_word=0x3C → stall=1 for 3 cycles, R1 stays unchanged, R1=0x3C on the 4th edge.
- Y=0x01, Bus_1=R0=0xFF, ADD, load_flags → flags N0 Z1 C1 V0. Follow with ADC of 0x00+0x00 → result 0x01.
- SUB with Y=0x01, Bus_1=0x80 → result 0x7F, V=1. SHR of 0x01 → 0x00, Z=1, C=1.
- PC=0xFF, inc_pc → 0x00. load_pc and inc_pc together with Bus_2=0x10 → PC=0x10.
- rst asserted in WAIT → next cycle FSM in IDLE, stall=0, all state 0, pending load discarded.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, bus encodings, FSM states and flag positions shared by processing_unit_param
package proc_pkg;
    localparam int OP_NOP = 0;
    localparam int OP_ADD = 1;
    localparam int OP_SUB = 2;
    localparam int OP_AND = 3;
    localparam int OP_NOT = 4;
    localparam int OP_RD  = 5;
    localparam int OP_WR  = 6;
    localparam int OP_BR  = 7;
    localparam int OP_BRZ = 8;
    localparam int OP_OR  = 9;
    localparam int OP_XOR = 10;
    localparam int OP_SHL = 11;
    localparam int OP_SHR = 12;
    localparam int OP_ADC = 13;

    typedef enum logic [1:0] {
        B2_ALU  = 2'd0,
        B2_BUS1 = 2'd1,
        B2_MEM  = 2'd2,
        B2_ZERO = 2'd3
    } bus2_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } rd_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_flags.sv
// alu_flags: combinational ALU (a = Y, b = Bus_1) with NZCV flag generation
module alu_flags
    import proc_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 4
) (
    input  logic [WORD_SIZE-1:0] i_a,
    input  logic [WORD_SIZE-1:0] i_b,
    input  logic [OP_SIZE-1:0]   i_op,
    input  logic                 i_carry,
    output logic [WORD_SIZE-1:0] o_result,
    output logic [3:0]           o_flags
);
    localparam int M = WORD_SIZE - 1;

    logic [WORD_SIZE:0] w_ext;
    logic               w_v;

    // Extended result: bit WORD_SIZE is the carry/borrow/shifted-out bit
    always_comb begin
        w_ext = '0;
        w_v   = 1'b0;
        case (int'(i_op))
            OP_ADD: begin
                w_ext = {1'b0, i_a} + {1'b0, i_b};
                w_v   = (i_a[M] == i_b[M]) && (w_ext[M] != i_a[M]);
            end
            OP_ADC: begin
                w_ext = {1'b0, i_a} + {1'b0, i_b} + (WORD_SIZE+1)'(i_carry);
                w_v   = (i_a[M] == i_b[M]) && (w_ext[M] != i_a[M]);
            end
            OP_SUB: begin
                w_ext = {1'b0, i_b} - {1'b0, i_a};
                w_v   = (i_b[M] != i_a[M]) && (w_ext[M] != i_b[M]);
            end
            OP_AND:  w_ext = {1'b0, i_a & i_b};
            OP_NOT:  w_ext = {1'b0, ~i_b};
            OP_OR:   w_ext = {1'b0, i_a | i_b};
            OP_XOR:  w_ext = {1'b0, i_a ^ i_b};
            OP_SHL:  w_ext = {i_b, 1'b0};
            OP_SHR:  w_ext = {i_b[0], 1'b0, i_b[M:1]};
            default: w_ext = '0;
        endcase
    end

    assign o_result         = w_ext[M:0];
    assign o_flags[FLAG_N]  = w_ext[M];
    assign o_flags[FLAG_Z]  = ~|w_ext[M:0];
    assign o_flags[FLAG_C]  = w_ext[WORD_SIZE];
    assign o_flags[FLAG_V]  = w_v;
endmodule

// File: rtl/processing_unit_param.sv
// processing_unit_param: register file, PC/IR/address/Y/flags and buses with a stalling memory-read handshake
module processing_unit_param
    import proc_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int NUM_REGS  = 4,
    parameter int OP_SIZE   = 4,
    parameter int RSEL      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] mem_word,
    input  logic                 mem_rd_valid,
    input  logic                 reg_wr_en,
    input  logic [RSEL-1:0]      reg_wr_sel,
    input  logic [RSEL:0]        bus1_sel,
    input  logic [1:0]           bus2_sel,
    input  logic                 load_pc,
    input  logic                 inc_pc,
    input  logic                 load_ir,
    input  logic                 load_addr,
    input  logic                 load_y,
    input  logic                 load_flags,
    output logic [WORD_SIZE-1:0] instruction,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] Bus_1,
    output logic [3:0]           flags,
    output logic                 mem_rd_req,
    output logic                 stall
);
    logic [WORD_SIZE-1:0] r_regs [NUM_REGS];
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_ir;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_y;
    logic [3:0]           r_flags;
    rd_state_e            r_state;
    rd_state_e            w_next;
    logic [WORD_SIZE-1:0] w_bus2;
    logic [WORD_SIZE-1:0] w_alu;
    logic [3:0]           w_alu_flags;
    logic                 w_any;

    assign w_any = reg_wr_en | load_pc | inc_pc | load_ir | load_addr | load_y | load_flags;

    assign Bus_1 = (bus1_sel < (RSEL+1)'(NUM_REGS)) ? r_regs[bus1_sel[RSEL-1:0]] :
                   (bus1_sel == (RSEL+1)'(NUM_REGS)) ? r_pc : '0;

    assign w_bus2 = (bus2_sel == B2_ALU)  ? w_alu :
                    (bus2_sel == B2_BUS1) ? Bus_1 :
                    (bus2_sel == B2_MEM)  ? mem_word : '0;

    assign instruction = r_ir;
    assign address     = r_addr;
    assign flags       = r_flags;

    alu_flags #(
        .WORD_SIZE (WORD_SIZE),
        .OP_SIZE   (OP_SIZE)
    ) u_alu (
        .i_a      (r_y),
        .i_b      (Bus_1),
        .i_op     (r_ir[WORD_SIZE-1 -: OP_SIZE]),
        .i_carry  (r_flags[FLAG_C]),
        .o_result (w_alu),
        .o_flags  (w_alu_flags)
    );

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Read FSM next state: wait while a memory-sourced load lacks valid data
    always_comb begin
        w_next = (r_state == ST_IDLE) ? (stall ? ST_WAIT : ST_IDLE) :
                 (mem_rd_valid ? ST_IDLE : ST_WAIT);
    end

    // Read FSM outputs: request while a memory-sourced load is pending, stall until data is valid
    always_comb begin
        mem_rd_req = (bus2_sel == B2_MEM) && w_any;
        stall      = mem_rd_req && !mem_rd_valid;
    end

    // Datapath state: every strobe loads Bus_2, all frozen while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs  <= '{default: '0};
            r_pc    <= '0;
            r_ir    <= '0;
            r_addr  <= '0;
            r_y     <= '0;
            r_flags <= '0;
        end else if (!stall) begin
            if (reg_wr_en)  r_regs[reg_wr_sel] <= w_bus2;
            if (load_pc)    r_pc <= w_bus2;
            else if (inc_pc) r_pc <= r_pc + WORD_SIZE'(1);
            if (load_ir)    r_ir <= w_bus2;
            if (load_addr)  r_addr <= w_bus2;
            if (load_y)     r_y <= w_bus2;
            if (load_flags) r_flags <= w_alu_flags;
        end
    end
endmodule

// File: tb/tb_processing_unit_param.sv
// tb_processing_unit_param: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_processing_unit_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem_word = '0;
    logic       mem_rd_valid = 1'b0;
    logic       reg_wr_en, load_pc, inc_pc, load_ir, load_addr, load_y, load_flags;
    logic [1:0] reg_wr_sel = '0;
    logic [2:0] bus1_sel = '0;
    logic [1:0] bus2_sel = '0;
    logic [6:0] st = '0;
    logic [7:0] instruction, address, Bus_1;
    logic [3:0] flags;
    logic       mem_rd_req, stall;

    localparam logic [6:0] S_WR = 7'b1000000, S_LPC = 7'b0100000, S_INC = 7'b0010000,
                           S_IR = 7'b0001000, S_ADDR = 7'b0000100, S_Y = 7'b0000010,
                           S_FL = 7'b0000001;
    localparam int C_BUS1 = 0, C_FLAGS = 1, C_STALL = 2, C_REQ = 3, C_IR = 4, C_ADDR = 5;

    assign {reg_wr_en, load_pc, inc_pc, load_ir, load_addr, load_y, load_flags} = st;

    typedef struct {
        int         code;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [7:0] act;
    int total = 0;
    int bad = 0;

    processing_unit_param dut (
        .clk          (clk),
        .rst          (rst),
        .mem_word     (mem_word),
        .mem_rd_valid (mem_rd_valid),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_sel   (reg_wr_sel),
        .bus1_sel     (bus1_sel),
        .bus2_sel     (bus2_sel),
        .load_pc      (load_pc),
        .inc_pc       (inc_pc),
        .load_ir      (load_ir),
        .load_addr    (load_addr),
        .load_y       (load_y),
        .load_flags   (load_flags),
        .instruction  (instruction),
        .address      (address),
        .Bus_1        (Bus_1),
        .flags        (flags),
        .mem_rd_req   (mem_rd_req),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    // Monitor: pop every pending expectation and compare against the DUT mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.code)
                C_BUS1:  act = Bus_1;
                C_FLAGS: act = {4'b0, flags};
                C_STALL: act = {7'b0, stall};
                C_REQ:   act = {7'b0, mem_rd_req};
                C_IR:    act = instruction;
                default: act = address;
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int c, input logic [7:0] x, input string n);
        q.push_back('{c, x, n});
    endtask

    task automatic set(input logic [2:0] b1, input logic [1:0] b2, input logic [1:0] ws,
                       input logic [7:0] mw, input logic v, input logic [6:0] s);
        bus1_sel = b1;
        bus2_sel = b2;
        reg_wr_sel = ws;
        mem_word = mw;
        mem_rd_valid = v;
        st = s;
    endtask

    task automatic ld(input logic [6:0] s, input logic [1:0] ws, input logic [7:0] v);
        set(3'd0, 2'd2, ws, v, 1'b1, s);
        tick();
    endtask

    task automatic alu_op(input logic [2:0] b1, input logic [1:0] ws);
        set(b1, 2'd0, ws, 8'h00, 1'b0, S_WR | S_FL);
        tick();
        set(3'(ws), 2'd0, 2'd0, 8'h00, 1'b0, 7'b0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        set(3'd0, 2'd0, 2'd0, 8'h00, 1'b0, 7'b0);
        chk(C_BUS1, 8'h00, "reset_r0");
        chk(C_IR, 8'h00, "reset_ir");
        chk(C_ADDR, 8'h00, "reset_addr");
        chk(C_FLAGS, 8'h00, "reset_flags");
        chk(C_STALL, 8'h00, "reset_stall");
        tick();
        bus1_sel = 3'd4;
        chk(C_BUS1, 8'h00, "reset_pc");
        tick();

        set(3'd2, 2'd2, 2'd2, 8'h5A, 1'b1, S_WR);
        chk(C_STALL, 8'h00, "fast_rd_stall");
        chk(C_REQ, 8'h01, "fast_rd_req");
        tick();
        set(3'd2, 2'd0, 2'd0, 8'h00, 1'b0, 7'b0);
        chk(C_BUS1, 8'h5A, "fast_rd_r2");
        tick();

        set(3'd1, 2'd2, 2'd1, 8'h77, 1'b0, S_WR);
        for (int i = 0; i < 3; i++) begin
            chk(C_STALL, 8'h01, "slow_rd_stall");
            chk(C_BUS1, 8'h00, "slow_rd_r1_hold");
            tick();
        end
        mem_word = 8'h3C;
        mem_rd_valid = 1'b1;
        chk(C_STALL, 8'h00, "slow_rd_valid_stall");
        chk(C_REQ, 8'h01, "slow_rd_valid_req");
        chk(C_BUS1, 8'h00, "slow_rd_r1_pre");
        tick();
        set(3'd1, 2'd0, 2'd0, 8'h00, 1'b0, 7'b0);
        chk(C_BUS1, 8'h3C, "slow_rd_r1");
        chk(C_REQ, 8'h00, "slow_rd_req_off");
        tick();

        ld(S_Y, 2'd0, 8'h01);
        ld(S_WR, 2'd0, 8'hFF);
        ld(S_IR, 2'd0, 8'h10);
        chk(C_IR, 8'h10, "ir_add");
        alu_op(3'd0, 2'd3);
        chk(C_BUS1, 8'h00, "add_result");
        chk(C_FLAGS, 8'h06, "add_flags");
        tick();

        ld(S_Y, 2'd0, 8'h00);
        ld(S_IR, 2'd0, 8'hD0);
        alu_op(3'd3, 2'd3);
        chk(C_BUS1, 8'h01, "adc_result");
        chk(C_FLAGS, 8'h00, "adc_flags");
        tick();

        ld(S_Y, 2'd0, 8'h01);
        ld(S_WR, 2'd0, 8'h80);
        ld(S_IR, 2'd0, 8'h20);
        alu_op(3'd0, 2'd3);
        chk(C_BUS1, 8'h7F, "sub_result");
        chk(C_FLAGS, 8'h01, "sub_flags");
        tick();

        ld(S_WR, 2'd0, 8'h01);
        ld(S_IR, 2'd0, 8'hC0);
        alu_op(3'd0, 2'd3);
        chk(C_BUS1, 8'h00, "shr_result");
        chk(C_FLAGS, 8'h06, "shr_flags");
        tick();

        ld(S_WR, 2'd0, 8'h81);
        ld(S_IR, 2'd0, 8'hB0);
        alu_op(3'd0, 2'd3);
        chk(C_BUS1, 8'h02, "shl_result");
        chk(C_FLAGS, 8'h02, "shl_flags");
        tick();

        ld(S_LPC, 2'd0, 8'hFF);
        set(3'd4, 2'd3, 2'd0, 8'h00, 1'b0, 7'b0);
        chk(C_BUS1, 8'hFF, "pc_load");
        tick();
        st = S_INC;
        tick();
        st = 7'b0;
        chk(C_BUS1, 8'h00, "pc_wrap");
        tick();
        ld(S_LPC | S_INC, 2'd0, 8'h10);
        set(3'd4, 2'd3, 2'd0, 8'h00, 1'b0, 7'b0);
        chk(C_BUS1, 8'h10, "pc_load_prio");
        tick();
        set(3'd4, 2'd1, 2'd1, 8'h00, 1'b0, S_WR);
        tick();
        set(3'd1, 2'd3, 2'd0, 8'h00, 1'b0, 7'b0);
        chk(C_BUS1, 8'h10, "bus1_copy");
        tick();
        bus1_sel = 3'd5;
        chk(C_BUS1, 8'h00, "bus1_unused_sel");
        tick();
        ld(S_ADDR, 2'd0, 8'hA5);
        set(3'd0, 2'd0, 2'd0, 8'h00, 1'b0, 7'b0);
        chk(C_ADDR, 8'hA5, "addr_load");
        tick();

        set(3'd2, 2'd2, 2'd2, 8'h99, 1'b0, S_WR | S_IR);
        chk(C_STALL, 8'h01, "wait_stall_a");
        tick();
        chk(C_STALL, 8'h01, "wait_stall_b");
        tick();
        rst = 1'b1;
        set(3'd2, 2'd3, 2'd2, 8'h99, 1'b0, 7'b0);
        tick();
        rst = 1'b0;
        chk(C_BUS1, 8'h00, "rst_wait_r2");
        chk(C_IR, 8'h00, "rst_wait_ir");
        chk(C_ADDR, 8'h00, "rst_wait_addr");
        chk(C_FLAGS, 8'h00, "rst_wait_flags");
        chk(C_STALL, 8'h00, "rst_wait_stall");
        set(3'd2, 2'd3, 2'd2, 8'h99, 1'b1, 7'b0);
        tick();
        chk(C_BUS1, 8'h00, "rst_wait_discard");
        tick();

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
